// File: rtl/event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : event_counter_bank
// Description : Bank of NUM_CH event counters with per-channel enable, global
//               freeze, synchronous clear, sticky overflow flags, a snapshot
//               shadow bank and a one-cycle-latency registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module event_counter_bank #(
    parameter int  NUM_CH    = 8,
    parameter int  CNT_WIDTH = 32,
    parameter int  INC_WIDTH = 2,
    parameter bit  SATURATE  = 1'b0,
    localparam int c_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*INC_WIDTH-1:0] evInc,
    input  logic [NUM_CH-1:0]           chEnable,
    input  logic                        freeze,
    input  logic                        clearReq,
    input  logic                        snapReq,
    input  logic                        rdReq,
    input  logic [c_IDX_W-1:0]          rdIdx,
    input  logic                        rdSnap,
    output logic                        rdValid,
    output logic [CNT_WIDTH-1:0]        rdData,
    output logic [NUM_CH-1:0]           ovfFlags,
    output logic                        snapValid
);

    // Per-channel views gathered for the read multiplexer.
    logic [CNT_WIDTH-1:0] w_live   [NUM_CH];
    logic [CNT_WIDTH-1:0] w_shadow [NUM_CH];
    logic [NUM_CH-1:0]    w_ovf;

    logic                 r_snap_valid;
    logic                 r_rd_valid;
    logic [CNT_WIDTH-1:0] r_rd_data;
    logic [CNT_WIDTH-1:0] w_rd_sel;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [INC_WIDTH-1:0] w_inc;
            logic [CNT_WIDTH:0]   w_sum;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [CNT_WIDTH-1:0] r_shadow;
            logic                 r_ovf;

            assign w_inc = evInc[gi*INC_WIDTH +: INC_WIDTH];
            // One extra bit so the carry-out directly signals overflow.
            assign w_sum = {1'b0, r_cnt} + {{(CNT_WIDTH+1-INC_WIDTH){1'b0}}, w_inc};

            // Live counter and sticky overflow: clear beats hold beats count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (clearReq) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (!freeze && chEnable[gi]) begin
                    if (w_sum[CNT_WIDTH]) begin
                        r_cnt <= SATURATE ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= w_sum[CNT_WIDTH-1:0];
                    end
                end
            end

            // Shadow captures the pre-update live value; freeze/clear do not matter.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_shadow <= '0;
                end else if (snapReq) begin
                    r_shadow <= r_cnt;
                end
            end

            assign w_live[gi]   = r_cnt;
            assign w_shadow[gi] = r_shadow;
            assign w_ovf[gi]    = r_ovf;
        end
    endgenerate

    // Flag that at least one snapshot exists since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_valid <= 1'b0;
        end else if (snapReq) begin
            r_snap_valid <= 1'b1;
        end
    end

    // Read source select; indices past the last channel read as zero.
    always_comb begin
        w_rd_sel = '0;
        if (32'(rdIdx) < NUM_CH) begin
            w_rd_sel = rdSnap ? w_shadow[rdIdx] : w_live[rdIdx];
        end
    end

    // Registered read port: data reflects state before the request edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rdReq;
            if (rdReq) begin
                r_rd_data <= w_rd_sel;
            end
        end
    end

    assign rdValid   = r_rd_valid;
    assign rdData    = r_rd_data;
    assign ovfFlags  = w_ovf;
    assign snapValid = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_event_counter_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_event_counter_bank
// Description : Directed self-checking bench for event_counter_bank. Two
//               instances (wrap and saturate) share one stimulus stream; read
//               expectations are queued at issue and checked on return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_counter_bank;

    localparam int NCH = 8;
    localparam int CW  = 8;
    localparam int IW  = 2;
    localparam int IDW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*IW-1:0] evInc;
    logic [NCH-1:0]    chEnable;
    logic              freeze, clearReq, snapReq, rdReq, rdSnap;
    logic [IDW-1:0]    rdIdx;

    logic              rdValid_w, snapValid_w, rdValid_s, snapValid_s;
    logic [CW-1:0]     rdData_w, rdData_s;
    logic [NCH-1:0]    ovf_w, ovf_s;

    int n_cmp = 0;
    int n_err = 0;
    logic [CW-1:0] q_w[$];
    logic [CW-1:0] q_s[$];
    logic [CW-1:0] last_w = '0;
    logic [CW-1:0] last_s = '0;

    always #5 clk = ~clk;

    event_counter_bank #(.NUM_CH(NCH), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .evInc(evInc), .chEnable(chEnable), .freeze(freeze),
        .clearReq(clearReq), .snapReq(snapReq), .rdReq(rdReq), .rdIdx(rdIdx),
        .rdSnap(rdSnap), .rdValid(rdValid_w), .rdData(rdData_w),
        .ovfFlags(ovf_w), .snapValid(snapValid_w)
    );

    event_counter_bank #(.NUM_CH(NCH), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .evInc(evInc), .chEnable(chEnable), .freeze(freeze),
        .clearReq(clearReq), .snapReq(snapReq), .rdReq(rdReq), .rdIdx(rdIdx),
        .rdSnap(rdSnap), .rdValid(rdValid_s), .rdData(rdData_s),
        .ovfFlags(ovf_s), .snapValid(snapValid_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the read port against the scoreboard.
    task automatic step();
        logic was_rd;
        was_rd = rdReq;
        @(posedge clk);
        #1;
        if (was_rd) begin
            chk("rdValid_wrap", 32'(rdValid_w), 32'd1);
            chk("rdValid_sat",  32'(rdValid_s), 32'd1);
            if (q_w.size() > 0) last_w = q_w.pop_front();
            if (q_s.size() > 0) last_s = q_s.pop_front();
        end else begin
            chk("rdValid_idle_wrap", 32'(rdValid_w), 32'd0);
            chk("rdValid_idle_sat",  32'(rdValid_s), 32'd0);
        end
        chk("rdData_wrap", 32'(rdData_w), 32'(last_w));
        chk("rdData_sat",  32'(rdData_s), 32'(last_s));
    endtask

    task automatic rd(input int idx, input logic snap, input logic [CW-1:0] ew, input logic [CW-1:0] es);
        rdReq  = 1'b1;
        rdIdx  = IDW'(idx);
        rdSnap = snap;
        q_w.push_back(ew);
        q_s.push_back(es);
        step();
        rdReq = 1'b0;
    endtask

    task automatic set_inc(input int ch, input logic [IW-1:0] v);
        evInc[ch*IW +: IW] = v;
    endtask

    task automatic chk_flags(input string tag, input logic [NCH-1:0] ew, input logic [NCH-1:0] es);
        chk({tag, "_wrap"}, 32'(ovf_w), 32'(ew));
        chk({tag, "_sat"},  32'(ovf_s), 32'(es));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdValid_wrap"},   32'(rdValid_w),   32'd0);
        chk({tag, "_rdData_wrap"},    32'(rdData_w),    32'd0);
        chk({tag, "_ovf_wrap"},       32'(ovf_w),       32'd0);
        chk({tag, "_snapValid_wrap"}, 32'(snapValid_w), 32'd0);
        chk({tag, "_rdValid_sat"},    32'(rdValid_s),   32'd0);
        chk({tag, "_rdData_sat"},     32'(rdData_s),    32'd0);
        chk({tag, "_ovf_sat"},        32'(ovf_s),       32'd0);
        chk({tag, "_snapValid_sat"},  32'(snapValid_s), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; evInc = '0; chEnable = '0; freeze = 1'b0; clearReq = 1'b0;
        snapReq = 1'b0; rdReq = 1'b0; rdIdx = '0; rdSnap = 1'b0;
        #12;
        chk_reset_outs("reset");
        rst = 1'b1;

        // a) ch0 +3 for 10 cycles, read back 30, then idle hold
        set_inc(0, 2'd3); chEnable = 8'h01;
        repeat (10) step();
        chEnable = '0; evInc = '0;
        rd(0, 1'b0, 8'd30, 8'd30);
        step();

        // b) ch1 to 254 then +3: wrap -> 1, saturate -> 255, flag set; then clear
        chEnable = 8'h02; set_inc(1, 2'd3);
        repeat (84) step();
        set_inc(1, 2'd2); step();
        set_inc(1, 2'd0);
        rd(1, 1'b0, 8'd254, 8'd254);
        chk_flags("ovf_before", 8'h00, 8'h00);
        set_inc(1, 2'd3); step();
        chk_flags("ovf_ch1_set", 8'h02, 8'h02);
        set_inc(1, 2'd0);
        rd(1, 1'b0, 8'd1, 8'd255);
        chk_flags("ovf_ch1_sticky", 8'h02, 8'h02);
        clearReq = 1'b1; step(); clearReq = 1'b0;
        chk_flags("ovf_cleared", 8'h00, 8'h00);
        rd(1, 1'b0, 8'd0, 8'd0);
        rd(0, 1'b0, 8'd0, 8'd0);

        // c) ch2 to 254, +3 then +1, then a zero increment at the ceiling
        chEnable = 8'h04; set_inc(2, 2'd3);
        repeat (84) step();
        set_inc(2, 2'd2); step();
        set_inc(2, 2'd3); step();
        chk_flags("ovf_ch2_set", 8'h04, 8'h04);
        set_inc(2, 2'd1); step();
        set_inc(2, 2'd0); step();
        rd(2, 1'b0, 8'd2, 8'd255);
        chk_flags("ovf_ch2_hold", 8'h04, 8'h04);
        chEnable = '0;

        // d) ch3 to 40; snap + clear + increment + live read in one cycle
        chk("snapValid_pre_wrap", 32'(snapValid_w), 32'd0);
        chk("snapValid_pre_sat",  32'(snapValid_s), 32'd0);
        chEnable = 8'h08; evInc = '0; set_inc(3, 2'd2);
        repeat (20) step();
        snapReq = 1'b1; clearReq = 1'b1;
        rdReq = 1'b1; rdIdx = 3'd3; rdSnap = 1'b0;
        q_w.push_back(8'd40); q_s.push_back(8'd40);
        step();
        snapReq = 1'b0; clearReq = 1'b0; rdReq = 1'b0; chEnable = '0; evInc = '0;
        chk("snapValid_post_wrap", 32'(snapValid_w), 32'd1);
        chk("snapValid_post_sat",  32'(snapValid_s), 32'd1);
        chk_flags("ovf_after_d", 8'h00, 8'h00);
        rd(3, 1'b0, 8'd0, 8'd0);
        rd(3, 1'b1, 8'd40, 8'd40);
        rd(2, 1'b1, 8'd2, 8'd255);
        rd(1, 1'b1, 8'd0, 8'd0);

        // e) ch0 to 5, then freeze 5 cycles with +1 everywhere; snap mid-freeze
        chEnable = 8'h01; set_inc(0, 2'd1);
        repeat (5) step();
        evInc = 16'h5555; chEnable = 8'hFF; freeze = 1'b1;
        step(); step();
        snapReq = 1'b1; step(); snapReq = 1'b0;
        step(); step();
        freeze = 1'b0; chEnable = '0; evInc = '0;
        rd(0, 1'b0, 8'd5, 8'd5);
        rd(4, 1'b0, 8'd0, 8'd0);
        rd(0, 1'b1, 8'd5, 8'd5);
        rd(3, 1'b1, 8'd0, 8'd0);
        chk_flags("ovf_after_freeze", 8'h00, 8'h00);

        // f) reset between edges while a read is returning
        chEnable = 8'h01; set_inc(0, 2'd1);
        rd(0, 1'b0, 8'd5, 8'd5);
        rdReq = 1'b1; rdIdx = 3'd0; rdSnap = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("async_reset");
        q_w.delete(); q_s.delete();
        last_w = '0; last_s = '0;
        rdReq = 1'b0;
        #10;
        rst = 1'b1;
        repeat (3) step();
        rd(0, 1'b0, 8'd3, 8'd3);
        rd(0, 1'b1, 8'd0, 8'd0);
        chk("snapValid_after_rst_wrap", 32'(snapValid_w), 32'd0);
        chk("snapValid_after_rst_sat",  32'(snapValid_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_counter_bank.md
EVENT_COUNTER_BANK -- requirements
Module: event_counter_bank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  NUM_CH  8  number of event channels.
  CNT_WIDTH  32  counter width in bits.
  INC_WIDTH  2  per-channel per-cycle increment width in bits; INC_WIDTH <= CNT_WIDTH.
  SATURATE  0  overflow mode: 1 = clamp at all-ones, 0 = wrap modulo 2^CNT_WIDTH.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  reset, asynchronous, active-low.
  evInc  in  NUM_CH*INC_WIDTH  per-channel increment; channel i occupies bits [i*INC_WIDTH +: INC_WIDTH].
  chEnable  in  NUM_CH  per-channel count enable.
  freeze  in  1  global hold; no counter changes while high.
  clearReq  in  1  synchronous clear of all live counters and overflow flags.
  snapReq  in  1  copy all live counters into shadow registers.
  rdReq  in  1  read request.
  rdIdx  in  max(1,$clog2(NUM_CH))  channel to read.
  rdSnap  in  1  read source: 1 = shadow, 0 = live.
  rdValid  out  1  read data valid.
  rdData  out  CNT_WIDTH  read data.
  ovfFlags  out  NUM_CH  sticky per-channel overflow flags.
  snapValid  out  1  at least one snapshot has been taken since reset.

Function
REQ-003 Each live counter cnt[i] SHALL update at every rising edge as follows, in priority order: clearReq -> 0; else freeze or !chEnable[i] -> hold; else cnt[i] + evInc[i].
REQ-004 The addition SHALL be computed at CNT_WIDTH+1 bits, with evInc[i] zero-extended.
REQ-005 On carry-out with SATURATE=1, cnt[i] SHALL become all-ones; with SATURATE=0, it SHALL become the low CNT_WIDTH bits of the sum.
REQ-006 On carry-out, ovfFlags[i] SHALL be set at the same edge, in either mode.
REQ-007 With SATURATE=1, a counter already at all-ones and receiving a nonzero increment SHALL stay at all-ones and set ovfFlags[i].
REQ-008 ovfFlags[i] SHALL stay set until clearReq or reset; clearReq SHALL take priority over a same-cycle overflow.
REQ-009 An increment of 0 SHALL never change a counter or its overflow flag.
REQ-010 When snapReq is high at an edge, shadow[i] SHALL capture cnt[i] as it was before that edge's update, for all channels simultaneously, and snapValid SHALL go to 1.
REQ-011 snapReq SHALL ignore freeze.
REQ-012 When snapReq and clearReq are high in the same cycle, the shadows SHALL hold the pre-clear values and the live counters SHALL become 0.
REQ-013 Shadows SHALL change only on snapReq or reset; clearReq SHALL NOT affect the shadows or snapValid.
REQ-014 Reads SHALL have a fixed latency of one cycle: rdReq high at edge N SHALL make rdValid=1 and rdData valid after edge N.
REQ-015 rdData SHALL be the selected live or shadow value as it was before edge N, so a read never observes the same-cycle increment, clear or snapshot.
REQ-016 rdValid SHALL be 0 in every cycle that follows an edge where rdReq=0; in those cycles rdData SHALL hold its previous value.
REQ-017 When rdIdx >= NUM_CH (NUM_CH not a power of two), rdData SHALL be 0 and rdValid SHALL be 1.
REQ-018 Back-to-back reads SHALL be accepted every cycle with no stall.
REQ-019 All state SHALL be registered; the block SHALL have no combinational path from inputs to outputs.

Reset
REQ-020 When rst=0, asynchronously: all live counters, shadows, ovfFlags, rdValid, rdData and snapValid SHALL be 0.
REQ-021 After rst returns to 1, counting SHALL resume at the first rising edge.
REQ-022 Reset asserted during a read SHALL drop rdValid to 0 immediately, and the read SHALL be lost.

Verification
REQ-023 The bench SHALL cover these directed scenarios (NUM_CH=8, CNT_WIDTH=8, INC_WIDTH=2 unless stated):
  a) ch0 evInc=3, chEnable=1, 10 cycles; then a read of idx0 -> rdData=30, rdValid one cycle after rdReq.
  b) SATURATE=0, cnt[1]=254, inc 3 -> cnt[1]=1, ovfFlags[1]=1; then clearReq -> cnt[1]=0, ovfFlags[1]=0.
  c) SATURATE=1, cnt[2]=254, inc 3 -> 255, ovfFlags[2]=1; a further inc 1 -> stays 255.
  d) cnt[3]=40, with snapReq, clearReq and inc 2 in the same cycle -> shadow[3]=40, live=0; rdSnap=1 read -> 40, snapValid=1.
  e) freeze high for 5 cycles with inc 1 on all channels -> no counter changes; snapReq during freeze still captures.
  f) rst pulsed low mid-operation between edges -> all outputs 0 immediately, before the next clk edge.
